// File: rtl/counter_monitor_pkg.sv
// counter_monitor_pkg: shared types and defaults for the counter monitor.
// The resync behaviour of the monitor is selected by COUNTER_MONITOR_RESYNC_EN.
package counter_monitor_pkg;

  // Monitor state encoding
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  // Default width of the error / wrap statistics counters
  localparam int STAT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Used for the monitor's error and wrap statistics; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  // Count up on inc, stop at all-ones, clear takes priority over inc
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// counter_monitor: passive checker for a free-running up-counter.
// Predicts cnt+1 (mod 2^WIDTH), flags mismatches, recognises restarts to 0,
// and keeps saturating error / wrap statistics.
// Build option COUNTER_MONITOR_RESYNC_EN: when defined, a mismatch resyncs the
// prediction and stays LOCKED (FAULT unreachable, fault tied 0); otherwise a
// mismatch latches FAULT until clr or reset.
//
// state       | meaning
// ST_UNLOCKED | no prediction yet; next valid sample seeds it
// ST_LOCKED   | tracking; each valid sample is checked against expected
// ST_FAULT    | mismatch seen (non-resync build); samples ignored until clr
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAT_W = STAT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              valid,
  input  logic [WIDTH-1:0]  cnt,
  output logic              locked,
  output logic              fault,
  output logic              mismatch,
  output logic              restart,
  output logic [WIDTH-1:0]  expected,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
);

  state_t           state;
  logic [WIDTH-1:0] cnt_inc;
  logic             take;
  logic             in_locked;
  logic             is_zero;
  logic             is_match;
  logic             hit_match;
  logic             hit_mismatch;
  logic             wrap_inc;

  assign cnt_inc   = cnt + WIDTH'(1);
  assign take      = valid && !clr;
  assign in_locked = (state == ST_LOCKED);
  assign is_zero   = (cnt == '0);
  assign is_match  = (cnt == expected);

  // A match on 0 in LOCKED can only follow an all-ones sample, since a restart
  // reseeds expected to 1 and clr drops back to UNLOCKED.
  assign hit_match    = in_locked && take && is_match;
  assign hit_mismatch = in_locked && take && !is_match && !is_zero;
  assign wrap_inc     = hit_match && is_zero;

`ifdef COUNTER_MONITOR_RESYNC_EN
  assign fault = 1'b0;
`endif

  // State machine, prediction register and registered status / pulse outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_UNLOCKED;
      expected <= '0;
      locked   <= 1'b0;
      mismatch <= 1'b0;
      restart  <= 1'b0;
`ifndef COUNTER_MONITOR_RESYNC_EN
      fault    <= 1'b0;
`endif
    end else begin
      mismatch <= 1'b0;
      restart  <= 1'b0;
      if (clr) begin
        state    <= ST_UNLOCKED;
        expected <= '0;
        locked   <= 1'b0;
`ifndef COUNTER_MONITOR_RESYNC_EN
        fault    <= 1'b0;
`endif
      end else if (valid) begin
        case (state)
          ST_UNLOCKED: begin
            expected <= cnt_inc;
            state    <= ST_LOCKED;
            locked   <= 1'b1;
          end
          ST_LOCKED: begin
            if (is_match) begin
              expected <= cnt_inc;
            end else if (is_zero) begin
              restart  <= 1'b1;
              expected <= WIDTH'(1);
            end else begin
              mismatch <= 1'b1;
`ifdef COUNTER_MONITOR_RESYNC_EN
              expected <= cnt_inc;
`else
              state    <= ST_FAULT;
              locked   <= 1'b0;
              fault    <= 1'b1;
`endif
            end
          end
          ST_FAULT: begin
          end
          default: begin
            state  <= ST_UNLOCKED;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(STAT_W)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (hit_mismatch),
    .value (err_count)
  );

  sat_counter #(.WIDTH(STAT_W)) u_wrap_count (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (wrap_inc),
    .value (wrap_count)
  );

endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor: scoreboard bench for counter_monitor.
// Three instances share clk/reset/clr/valid: WIDTH=8 (a_), WIDTH=3 (b_),
// WIDTH=8 with STAT_W=2 (c_). Expectations follow COUNTER_MONITOR_RESYNC_EN.
module tb_counter_monitor;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       valid;
  logic [7:0] cnt8;
  logic [2:0] cnt3;

  logic        a_locked, a_fault, a_mismatch, a_restart;
  logic [7:0]  a_expected;
  logic [15:0] a_err, a_wrap;
  logic        b_locked, b_fault, b_mismatch, b_restart;
  logic [2:0]  b_expected;
  logic [15:0] b_err, b_wrap;
  logic        c_locked, c_fault, c_mismatch, c_restart;
  logic [7:0]  c_expected;
  logic [1:0]  c_err, c_wrap;

  counter_monitor #(.WIDTH(8), .STAT_W(16)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .valid(valid), .cnt(cnt8),
    .locked(a_locked), .fault(a_fault), .mismatch(a_mismatch), .restart(a_restart),
    .expected(a_expected), .err_count(a_err), .wrap_count(a_wrap)
  );

  counter_monitor #(.WIDTH(3), .STAT_W(16)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .valid(valid), .cnt(cnt3),
    .locked(b_locked), .fault(b_fault), .mismatch(b_mismatch), .restart(b_restart),
    .expected(b_expected), .err_count(b_err), .wrap_count(b_wrap)
  );

  counter_monitor #(.WIDTH(8), .STAT_W(2)) dut_c (
    .clk(clk), .reset(reset), .clr(clr), .valid(valid), .cnt(cnt8),
    .locked(c_locked), .fault(c_fault), .mismatch(c_mismatch), .restart(c_restart),
    .expected(c_expected), .err_count(c_err), .wrap_count(c_wrap)
  );

  typedef struct packed {
    logic        locked;
    logic        fault;
    logic        mismatch;
    logic        restart;
    logic [7:0]  expv;
    logic [15:0] err;
    logic [15:0] wrap;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic l, input logic f, input logic m, input logic r,
                              input logic [7:0] e, input logic [15:0] er, input logic [15:0] w);
    return {l, f, m, r, e, er, w};
  endfunction

  function automatic exp_t obs(input int which);
    exp_t o;
    case (which)
      0:       o = {a_locked, a_fault, a_mismatch, a_restart, a_expected, a_err, a_wrap};
      1:       o = {b_locked, b_fault, b_mismatch, b_restart, {5'b0, b_expected}, b_err, b_wrap};
      default: o = {c_locked, c_fault, c_mismatch, c_restart, c_expected, {14'b0, c_err}, {14'b0, c_wrap}};
    endcase
    return o;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    clr   = 1'b0;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got, want;
    valid = 1'b1;
    cnt8  = 8'd7;
    cnt3  = 3'd2;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 16'd0));
      got  = obs(k);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset[dut%0d]: got %h, want %h", k, got, want);
      end
    end
    valid = 1'b0;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_lock_track();
    exp_t got, want;
    logic [7:0] seq [4];
    seq = '{8'd5, 8'd6, 8'd7, 8'd8};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        valid = 1'b1;
        cnt8  = seq[i];
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, seq[i] + 8'd1, 16'd0, 16'd0));
      end else begin
        valid = 1'b0;
        cnt8  = 8'd77;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 16'd0, 16'd0));
      end
      @(posedge clk); #1;
      got  = obs(0);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL lock_track[%0d]: got %h, want %h", i, got, want);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t got, want;
    logic [2:0]  c, n;
    logic [15:0] wr;
    wr = 16'd0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      c = 3'(i % 8);
      n = c + 3'd1;
      if (c == 3'd0 && i > 0) wr = wr + 16'd1;
      valid = 1'b1;
      cnt3  = c;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, {5'b0, n}, 16'd0, wr));
      @(posedge clk); #1;
      got  = obs(1);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %h, want %h", i, got, want);
      end
    end
  endtask

  task automatic test_restart();
    exp_t got, want;
    logic [7:0] seq [5];
    logic [7:0] nxt [5];
    logic       rs  [5];
    seq = '{8'd40, 8'd41, 8'd42, 8'd0, 8'd1};
    nxt = '{8'd41, 8'd42, 8'd43, 8'd1, 8'd2};
    rs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      cnt8  = seq[i];
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, rs[i], nxt[i], 16'd0, 16'd0));
      @(posedge clk); #1;
      got  = obs(0);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL restart[%0d]: got %h, want %h", i, got, want);
      end
    end
  endtask

  task automatic test_mismatch();
    exp_t got, want;
    logic [7:0]  seq [4];
    logic [7:0]  nxt [4];
    logic        lk  [4];
    logic        ft  [4];
    logic        ms  [4];
    logic [15:0] er  [4];
    seq = '{8'd10, 8'd11, 8'd13, 8'd14};
    ms  = '{1'b0, 1'b0, 1'b1, 1'b0};
    er  = '{16'd0, 16'd0, 16'd1, 16'd1};
`ifdef COUNTER_MONITOR_RESYNC_EN
    nxt = '{8'd11, 8'd12, 8'd14, 8'd15};
    lk  = '{1'b1, 1'b1, 1'b1, 1'b1};
    ft  = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    nxt = '{8'd11, 8'd12, 8'd12, 8'd12};
    lk  = '{1'b1, 1'b1, 1'b0, 1'b0};
    ft  = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      cnt8  = seq[i];
      exp_q.push_back(mk(lk[i], ft[i], ms[i], 1'b0, nxt[i], er[i], 16'd0));
      @(posedge clk); #1;
      got  = obs(0);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL mismatch[%0d]: got %h, want %h", i, got, want);
      end
    end
  endtask

  task automatic test_clear_priority();
    exp_t got, want;
    clr   = 1'b1;
    valid = 1'b1;
    cnt8  = 8'd3;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 16'd0));
    @(posedge clk); #1;
    got  = obs(0);
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL clr_priority: got %h, want %h", got, want);
    end
    clr = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 16'd0, 16'd0));
    @(posedge clk); #1;
    got  = obs(0);
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL clr_relock: got %h, want %h", got, want);
    end
  endtask

  task automatic test_saturation();
    exp_t got, want;
    logic [7:0]  seq [6];
    logic [7:0]  nxt [6];
    logic        lk  [6];
    logic        ft  [6];
    logic        ms  [6];
    logic [15:0] er  [6];
    seq = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
`ifdef COUNTER_MONITOR_RESYNC_EN
    nxt = '{8'd11, 8'd21, 8'd31, 8'd41, 8'd51, 8'd61};
    lk  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ft  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ms  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    er  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
`else
    nxt = '{8'd11, 8'd11, 8'd11, 8'd11, 8'd11, 8'd11};
    lk  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ft  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ms  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    er  = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
`endif
    do_reset();
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1;
      cnt8  = seq[i];
      exp_q.push_back(mk(lk[i], ft[i], ms[i], 1'b0, nxt[i], er[i], 16'd0));
      @(posedge clk); #1;
      got  = obs(2);
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL saturation[%0d]: got %h, want %h", i, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t got, want;
    do_reset();
    valid = 1'b1;
    cnt8  = 8'd10;
    @(posedge clk); #1;
    cnt8  = 8'd20;
    @(posedge clk); #1;
    cnt8  = 8'd30;
`ifdef COUNTER_MONITOR_RESYNC_EN
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd31, 16'd2, 16'd0));
`else
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd11, 16'd1, 16'd0));
`endif
    @(posedge clk); #1;
    got  = obs(0);
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL async_pre: got %h, want %h", got, want);
    end
    #3;
    reset = 1'b1;
    valid = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 16'd0));
    #1;
    got  = obs(0);
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL async_mid: got %h, want %h", got, want);
    end
    #2;
    reset = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 16'd0));
    @(posedge clk); #1;
    got  = obs(0);
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL async_after: got %h, want %h", got, want);
    end
  endtask

  initial begin
    reset = 1'b1;
    clr   = 1'b0;
    valid = 1'b0;
    cnt8  = 8'd0;
    cnt3  = 3'd0;
    test_reset();
    test_lock_track();
    test_wrap();
    test_restart();
    test_mismatch();
    test_clear_priority();
    test_saturation();
    test_async_reset();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
